// File: rtl/video_pkg.sv
// Shared video pipeline definitions: sprite register map, sprite geometry and
// the timing bundle that travels alongside pixel data through every stage.
package video_pkg;

    localparam int SPRITE_SIZE = 16;

    localparam logic [4:0] SPR_XPOS   = 5'h00;
    localparam logic [4:0] SPR_YPOS   = 5'h01;
    localparam logic [4:0] SPR_COLOUR = 5'h02;
    localparam logic [4:0] SPR_CTRL   = 5'h03;
    localparam logic [4:0] SPR_ROW0   = 5'h10;

    typedef struct packed {
        logic visible;
        logic end_of_line;
        logic end_of_frame;
        logic hsync_n;
        logic vsync_n;
    } video_timing_t;

    // Syncs are active low, so the idle bundle keeps them high.
    localparam video_timing_t TIMING_IDLE = '{
        visible: 1'b0, end_of_line: 1'b0, end_of_frame: 1'b0,
        hsync_n: 1'b1, vsync_n: 1'b1
    };

    // Field order puts enable on data bit 0 and invert on data bit 1.
    typedef struct packed {
        logic invert;
        logic enable;
    } sprite_ctrl_t;

endpackage

// File: rtl/sprite_overlay_if.sv
// Simple synchronous register write port used to configure the sprite stage.
interface sprite_overlay_if;
    logic        we;
    logic [4:0]  addr;
    logic [23:0] data;

    modport master (output we, output addr, output data);
    modport slave  (input  we, input  addr, input  data);
endinterface

// File: rtl/sprite_regs.sv
// Shadow/active sprite register file; active copies reload from the shadows
// only on the end-of-frame cycle so a frame is always drawn with one config.
module sprite_regs
    import video_pkg::*;
#(
    parameter int X_BITS = 11,
    parameter int Y_BITS = 10
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    sprite_overlay_if.slave                          cfg,
    input  logic                                     frame_latch_i,
    output logic [X_BITS-1:0]                        xpos_o,
    output logic [Y_BITS-1:0]                        ypos_o,
    output logic [23:0]                              colour_o,
    output sprite_ctrl_t                             ctrl_o,
    output logic [SPRITE_SIZE-1:0][SPRITE_SIZE-1:0]  rows_o
);

    logic [X_BITS-1:0] sh_xpos_q, sh_xpos_d, act_xpos_q, act_xpos_d;
    logic [Y_BITS-1:0] sh_ypos_q, sh_ypos_d, act_ypos_q, act_ypos_d;
    logic [23:0]       sh_colour_q, sh_colour_d, act_colour_q, act_colour_d;
    sprite_ctrl_t      sh_ctrl_q, sh_ctrl_d, act_ctrl_q, act_ctrl_d;

    // The latch reads the shadow flops, so a write in the latch cycle lands a frame later.
    always_comb begin
        sh_xpos_d    = sh_xpos_q;
        sh_ypos_d    = sh_ypos_q;
        sh_colour_d  = sh_colour_q;
        sh_ctrl_d    = sh_ctrl_q;
        act_xpos_d   = act_xpos_q;
        act_ypos_d   = act_ypos_q;
        act_colour_d = act_colour_q;
        act_ctrl_d   = act_ctrl_q;
        if (frame_latch_i) begin
            act_xpos_d   = sh_xpos_q;
            act_ypos_d   = sh_ypos_q;
            act_colour_d = sh_colour_q;
            act_ctrl_d   = sh_ctrl_q;
        end
        if (cfg.we) begin
            case (cfg.addr)
                SPR_XPOS:   sh_xpos_d   = cfg.data[X_BITS-1:0];
                SPR_YPOS:   sh_ypos_d   = cfg.data[Y_BITS-1:0];
                SPR_COLOUR: sh_colour_d = cfg.data;
                SPR_CTRL:   sh_ctrl_d   = sprite_ctrl_t'(cfg.data[1:0]);
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_xpos_q    <= '0;
            sh_ypos_q    <= '0;
            sh_colour_q  <= '0;
            sh_ctrl_q    <= '0;
            act_xpos_q   <= '0;
            act_ypos_q   <= '0;
            act_colour_q <= '0;
            act_ctrl_q   <= '0;
        end else begin
            sh_xpos_q    <= sh_xpos_d;
            sh_ypos_q    <= sh_ypos_d;
            sh_colour_q  <= sh_colour_d;
            sh_ctrl_q    <= sh_ctrl_d;
            act_xpos_q   <= act_xpos_d;
            act_ypos_q   <= act_ypos_d;
            act_colour_q <= act_colour_d;
            act_ctrl_q   <= act_ctrl_d;
        end
    end

    for (genvar gi = 0; gi < SPRITE_SIZE; gi++) begin : g_row
        logic [SPRITE_SIZE-1:0] sh_row_q, sh_row_d, act_row_q, act_row_d;

        always_comb begin
            sh_row_d  = sh_row_q;
            act_row_d = act_row_q;
            if (frame_latch_i) begin
                act_row_d = sh_row_q;
            end
            if (cfg.we && (cfg.addr == SPR_ROW0 + 5'(gi))) begin
                sh_row_d = cfg.data[SPRITE_SIZE-1:0];
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                sh_row_q  <= '0;
                act_row_q <= '0;
            end else begin
                sh_row_q  <= sh_row_d;
                act_row_q <= act_row_d;
            end
        end

        assign rows_o[gi] = act_row_q;
    end

    assign xpos_o   = act_xpos_q;
    assign ypos_o   = act_ypos_q;
    assign colour_o = act_colour_q;
    assign ctrl_o   = act_ctrl_q;

endmodule

// File: rtl/sprite_overlay.sv
// 16x16 1bpp cursor overlay: stage 1 tracks the raster position and hit-tests
// the bitmap, stage 2 composites the colour; timing follows with equal latency.
module sprite_overlay
    import video_pkg::*;
#(
    parameter int X_BITS = 11,
    parameter int Y_BITS = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             visible_i,
    input  logic             end_of_line_i,
    input  logic             end_of_frame_i,
    input  logic             hsync_n_i,
    input  logic             vsync_n_i,
    input  logic [23:0]      rgb_i,
    output logic             visible_o,
    output logic             end_of_line_o,
    output logic             end_of_frame_o,
    output logic             hsync_n_o,
    output logic             vsync_n_o,
    output logic [23:0]      rgb_o,
    sprite_overlay_if.slave  cfg
);

    logic [X_BITS-1:0]                       act_xpos;
    logic [Y_BITS-1:0]                       act_ypos;
    logic [23:0]                             act_colour;
    sprite_ctrl_t                            act_ctrl;
    logic [SPRITE_SIZE-1:0][SPRITE_SIZE-1:0] act_rows;

    sprite_regs #(.X_BITS(X_BITS), .Y_BITS(Y_BITS)) u_regs (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cfg           (cfg),
        .frame_latch_i (end_of_frame_i),
        .xpos_o        (act_xpos),
        .ypos_o        (act_ypos),
        .colour_o      (act_colour),
        .ctrl_o        (act_ctrl),
        .rows_o        (act_rows)
    );

    logic [X_BITS-1:0] x_q, x_d, dx;
    logic [Y_BITS-1:0] y_q, y_d, dy;
    logic              hit;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (end_of_line_i) begin
            x_d = '0;
        end else if (visible_i) begin
            x_d = x_q + X_BITS'(1);
        end
        if (end_of_frame_i) begin
            y_d = '0;
        end else if (end_of_line_i) begin
            y_d = y_q + Y_BITS'(1);
        end
    end

    // Unsigned differences make positions left/above the sprite wrap to large values.
    assign dx  = x_q - act_xpos;
    assign dy  = y_q - act_ypos;
    assign hit = act_ctrl.enable & visible_i
               & (dx < X_BITS'(SPRITE_SIZE)) & (dy < Y_BITS'(SPRITE_SIZE))
               & act_rows[dy[3:0]][~dx[3:0]];

    video_timing_t s1_tim_q, s1_tim_d, out_tim_q;
    logic [23:0]   s1_rgb_q, s1_colour_q, out_rgb_q, out_rgb_d;
    logic          s1_hit_q, s1_invert_q;

    always_comb begin
        s1_tim_d = '{visible: visible_i, end_of_line: end_of_line_i,
                     end_of_frame: end_of_frame_i, hsync_n: hsync_n_i,
                     vsync_n: vsync_n_i};
        out_rgb_d = s1_rgb_q;
        if (s1_hit_q) begin
            out_rgb_d = s1_invert_q ? ~s1_rgb_q : s1_colour_q;
        end
    end

    // Colour and mode travel with the hit so a frame latch cannot split a pixel.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q         <= '0;
            y_q         <= '0;
            s1_tim_q    <= TIMING_IDLE;
            s1_rgb_q    <= '0;
            s1_hit_q    <= 1'b0;
            s1_invert_q <= 1'b0;
            s1_colour_q <= '0;
            out_tim_q   <= TIMING_IDLE;
            out_rgb_q   <= '0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            s1_tim_q    <= s1_tim_d;
            s1_rgb_q    <= rgb_i;
            s1_hit_q    <= hit;
            s1_invert_q <= act_ctrl.invert;
            s1_colour_q <= act_colour;
            out_tim_q   <= s1_tim_q;
            out_rgb_q   <= out_rgb_d;
        end
    end

    assign visible_o      = out_tim_q.visible;
    assign end_of_line_o  = out_tim_q.end_of_line;
    assign end_of_frame_o = out_tim_q.end_of_frame;
    assign hsync_n_o      = out_tim_q.hsync_n;
    assign vsync_n_o      = out_tim_q.vsync_n;
    assign rgb_o          = out_rgb_q;

endmodule

// File: tb/tb_sprite_overlay.sv
// Directed frame sequence with random pixels/syncs, checked cycle by cycle
// against a coordinate-based sprite model fed through a two-cycle delay.
module tb_sprite_overlay;
    import video_pkg::*;

    localparam int X_BITS = 11;
    localparam int Y_BITS = 10;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic        rst_i, visible_i, end_of_line_i, end_of_frame_i, hsync_n_i, vsync_n_i;
    logic [23:0] rgb_i;
    logic        visible_o, end_of_line_o, end_of_frame_o, hsync_n_o, vsync_n_o;
    logic [23:0] rgb_o;

    sprite_overlay_if cfg_bus();

    sprite_overlay #(.X_BITS(X_BITS), .Y_BITS(Y_BITS)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .visible_i      (visible_i),
        .end_of_line_i  (end_of_line_i),
        .end_of_frame_i (end_of_frame_i),
        .hsync_n_i      (hsync_n_i),
        .vsync_n_i      (vsync_n_i),
        .rgb_i          (rgb_i),
        .visible_o      (visible_o),
        .end_of_line_o  (end_of_line_o),
        .end_of_frame_o (end_of_frame_o),
        .hsync_n_o      (hsync_n_o),
        .vsync_n_o      (vsync_n_o),
        .rgb_o          (rgb_o),
        .cfg            (cfg_bus)
    );

    typedef struct {
        logic [4:0]  a;
        logic [23:0] d;
    } wr_t;

    typedef struct {
        logic [4:0]  tim;
        logic [23:0] rgb;
        logic [23:0] rgb_in;
        int          x;
        int          y;
        int          frame;
        logic        vis;
    } exp_t;

    wr_t  wq[$];
    exp_t d1, d2;
    int   checks = 0;
    int   errors = 0;

    // Model configuration: what software wrote, and what the current frame uses.
    int          sh_xpos, sh_ypos, act_xpos, act_ypos;
    logic [23:0] sh_colour, act_colour;
    bit          sh_en, sh_inv, act_en, act_inv;
    logic [15:0] sh_rows[16];
    logic [15:0] act_rows[16];

    function automatic exp_t idle_exp();
        exp_t e;
        e.tim = 5'b00011; e.rgb = '0; e.rgb_in = '0;
        e.x = -1; e.y = -1; e.frame = -1; e.vis = 1'b0;
        return e;
    endfunction

    task automatic model_clear();
        sh_xpos = 0; sh_ypos = 0; sh_colour = '0; sh_en = 0; sh_inv = 0;
        act_xpos = 0; act_ypos = 0; act_colour = '0; act_en = 0; act_inv = 0;
        for (int i = 0; i < 16; i++) begin
            sh_rows[i] = '0;
            act_rows[i] = '0;
        end
    endtask

    task automatic model_latch();
        act_xpos = sh_xpos; act_ypos = sh_ypos; act_colour = sh_colour;
        act_en = sh_en; act_inv = sh_inv;
        for (int i = 0; i < 16; i++) act_rows[i] = sh_rows[i];
    endtask

    task automatic model_write(input logic [4:0] a, input logic [23:0] d);
        if (a == 5'h00)      sh_xpos = int'(d[10:0]);
        else if (a == 5'h01) sh_ypos = int'(d[9:0]);
        else if (a == 5'h02) sh_colour = d;
        else if (a == 5'h03) begin sh_en = d[0]; sh_inv = d[1]; end
        else if (a >= 5'h10) sh_rows[int'(a) - 16] = d[15:0];
    endtask

    function automatic bit model_hit(input int x, input int y);
        int col, row;
        col = x - act_xpos;
        row = y - act_ypos;
        if (!act_en || col < 0 || col > 15 || row < 0 || row > 15) return 1'b0;
        return act_rows[row][15 - col];
    endfunction

    // Register write with random junk in the bits the register does not use.
    function automatic wr_t mk_wr(input logic [4:0] a, input logic [23:0] val, input logic [23:0] keep);
        wr_t w;
        logic [23:0] junk;
        junk = 24'($urandom);
        w.a = a;
        w.d = (junk & ~keep) | (val & keep);
        return w;
    endfunction

    task automatic chk(input string tag, input exp_t e, input logic [23:0] obs, input logic [23:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s f%0d x%0d y%0d: got %h expected %h", tag, e.frame, e.x, e.y, obs, want);
        end
    endtask

    task automatic cycle(input logic vis, input logic eol, input logic eof,
                         input logic hs, input logic vs, input logic [23:0] rgb,
                         input int x, input int y, input int frame, input logic rst,
                         input logic we, input logic [4:0] a, input logic [23:0] d);
        exp_t e;
        rst_i = rst; visible_i = vis; end_of_line_i = eol; end_of_frame_i = eof;
        hsync_n_i = hs; vsync_n_i = vs; rgb_i = rgb;
        cfg_bus.we = we; cfg_bus.addr = a; cfg_bus.data = d;
        e = idle_exp();
        if (rst) begin
            model_clear();
        end else begin
            e.tim = {vis, eol, eof, hs, vs};
            e.rgb_in = rgb; e.x = x; e.y = y; e.frame = frame; e.vis = vis;
            e.rgb = rgb;
            if (vis && model_hit(x, y)) e.rgb = act_inv ? ~rgb : act_colour;
            if (eof) model_latch();
            if (we) model_write(a, d);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            d1 = idle_exp(); d2 = idle_exp();
        end else begin
            d2 = d1; d1 = e;
        end
        chk("timing", d2, {19'd0, visible_o, end_of_line_o, end_of_frame_o, hsync_n_o, vsync_n_o},
            {19'd0, d2.tim});
        chk("rgb", d2, rgb_o, d2.rgb);
        if (d2.vis) begin
            if (d2.frame == 2 && d2.y == 50) begin
                if (d2.x == 100 || d2.x == 115) chk("basic_hit", d2, rgb_o, 24'hFF0000);
                if (d2.x == 99 || d2.x == 101 || d2.x == 116) chk("basic_pass", d2, rgb_o, d2.rgb_in);
            end
            if (d2.frame == 3 && d2.y == 50 && d2.x == 20) chk("tear_new", d2, rgb_o, 24'hFF0000);
            if (d2.frame == 3 && d2.y == 50 && d2.x == 100) chk("tear_old", d2, rgb_o, d2.rgb_in);
            if (d2.frame == 4 && d2.y == 5 && d2.x == 20) chk("eof_write", d2, rgb_o, 24'hFF0000);
            if (d2.frame == 5 && d2.x >= 20 && d2.x < 36 && d2.y >= 5 && d2.y < 21)
                chk("invert", d2, rgb_o, 24'hEDCBA9);
            if (d2.frame == 6 && d2.y == 1 && d2.x < 8) chk("clip_wrap", d2, rgb_o, d2.rgb_in);
            if (d2.frame == 6 && d2.y == 1 && d2.x >= 632) chk("clip_draw", d2, rgb_o, 24'hFF0000);
            if (d2.frame == 8 && d2.y == 0 && d2.x < 16) chk("post_reset", d2, rgb_o, 24'h00FF00);
            if (d2.frame == 8 && d2.y == 1 && d2.x < 16) chk("rows_cleared", d2, rgb_o, d2.rgb_in);
        end
    endtask

    // One frame: w visible pixels then 4 blanking cycles per line, h lines.
    task automatic run_frame(input int frame, input int w, input int h,
                             input bit fixed_en, input logic [23:0] fixed_rgb,
                             input int wr_line, input int rst_line,
                             input bit eofw, input wr_t eof_wr);
        logic vis, eol, eof, we;
        logic [23:0] rgb;
        wr_t w_now;
        for (int l = 0; l < h; l++) begin
            for (int p = 0; p < w + 4; p++) begin
                vis = (p < w);
                eol = (p == w - 1);
                eof = eol && (l == h - 1);
                rgb = (fixed_en && vis) ? fixed_rgb : 24'($urandom);
                we = 1'b0;
                w_now.a = '0; w_now.d = '0;
                if (eof && eofw) begin
                    we = 1'b1; w_now = eof_wr;
                end else if (wr_line >= 0 && l >= wr_line && wq.size() > 0) begin
                    we = 1'b1; w_now = wq.pop_front();
                end
                cycle(vis, eol, eof, 1'($urandom), 1'($urandom), rgb,
                      vis ? p : -1, l, frame, (l == rst_line && p == 2),
                      we, w_now.a, w_now.d);
            end
        end
    endtask

    initial begin
        wr_t none;
        none.a = '0; none.d = '0;
        d1 = idle_exp(); d2 = idle_exp();
        model_clear();

        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'($urandom), i, 0, -1, 1'b1, 1'b0, 5'h0, 24'h0);

        run_frame(0, 64, 4, 0, 24'h0, -1, -1, 0, none);

        wq.push_back(mk_wr(SPR_XPOS, 24'd100, 24'h0007FF));
        wq.push_back(mk_wr(SPR_YPOS, 24'd50, 24'h0003FF));
        wq.push_back(mk_wr(SPR_COLOUR, 24'hFF0000, 24'hFFFFFF));
        wq.push_back(mk_wr(SPR_CTRL, 24'h1, 24'h000003));
        wq.push_back(mk_wr(SPR_ROW0, 24'h8001, 24'h00FFFF));
        run_frame(1, 16, 2, 0, 24'h0, 0, -1, 0, none);

        for (int i = 0; i < 3; i++) wq.push_back(mk_wr(5'(4 + $urandom_range(0, 11)), 24'($urandom), 24'hFFFFFF));
        wq.push_back(mk_wr(SPR_XPOS, 24'd20, 24'h0007FF));
        run_frame(2, 120, 52, 0, 24'h0, 10, -1, 1, mk_wr(SPR_YPOS, 24'd5, 24'h0003FF));

        run_frame(3, 120, 52, 0, 24'h0, -1, -1, 0, none);

        wq.push_back(mk_wr(SPR_CTRL, 24'h3, 24'h000003));
        for (int i = 0; i < 16; i++) wq.push_back(mk_wr(SPR_ROW0 + 5'(i), 24'hFFFF, 24'h00FFFF));
        run_frame(4, 40, 22, 0, 24'h0, 0, -1, 0, none);

        wq.push_back(mk_wr(SPR_XPOS, 24'd632, 24'h0007FF));
        wq.push_back(mk_wr(SPR_YPOS, 24'd0, 24'h0003FF));
        wq.push_back(mk_wr(SPR_CTRL, 24'h1, 24'h000003));
        run_frame(5, 40, 22, 1, 24'h123456, 0, -1, 0, none);

        run_frame(6, 640, 3, 0, 24'h0, -1, -1, 0, none);

        wq.push_back(mk_wr(SPR_CTRL, 24'h1, 24'h000003));
        wq.push_back(mk_wr(SPR_XPOS, 24'd0, 24'h0007FF));
        wq.push_back(mk_wr(SPR_YPOS, 24'd0, 24'h0003FF));
        wq.push_back(mk_wr(SPR_COLOUR, 24'h00FF00, 24'hFFFFFF));
        wq.push_back(mk_wr(SPR_ROW0, 24'hFFFF, 24'h00FFFF));
        run_frame(7, 32, 4, 0, 24'h0, 2, 1, 0, none);

        run_frame(8, 32, 4, 0, 24'h0, -1, -1, 0, none);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
